// File: rtl/flash_read_ctrl.sv
// ---------------------------------------------------------------------------
// flash_read_ctrl
//
// Converts the audio address sequencer's level request (start + address +
// byteenable) into one single-word Avalon-MM read of the flash controller,
// then returns the word with a one-cycle finish pulse.
//
// Optional feature macro: FLASH_TIMEOUT_EN
//   When defined, a watchdog counter forces completion after TIMEOUT_CYCLES
//   cycles spent in ISSUE/WAIT_VALID. The forced completion returns zero
//   data and sets the sticky timeout_err flag.
//   When undefined, the block waits forever and timeout_err is tied low.
//
// Ports:
//   clk, reset_n              system clock / asynchronous active-low reset
//   start                     level request, only sampled in IDLE
//   address, byteenable       request fields, captured when start is accepted
//   finish                    one-cycle pulse, data_out valid (to endFlash)
//   data_out                  last word read, held until the next completion
//   timeout_err               sticky: last transaction timed out
//   flash_mem_*               Avalon-MM master toward the flash controller
// ---------------------------------------------------------------------------
module flash_read_ctrl #(
   parameter int ADDR_W         = 23,
   parameter int DATA_W         = 32,
   parameter int TIMEOUT_CYCLES = 255
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              start,
   input  logic [ADDR_W-1:0] address,
   input  logic [3:0]        byteenable,
   output logic              finish,
   output logic [DATA_W-1:0] data_out,
   output logic              timeout_err,
   output logic              flash_mem_read,
   output logic [ADDR_W-1:0] flash_mem_address,
   output logic [3:0]        flash_mem_byteenable,
   output logic [5:0]        flash_mem_burstcount,
   input  logic              flash_mem_waitrequest,
   input  logic [DATA_W-1:0] flash_mem_readdata,
   input  logic              flash_mem_readdatavalid
);

   localparam logic [1:0] IDLE       = 2'd0;
   localparam logic [1:0] ISSUE      = 2'd1;
   localparam logic [1:0] WAIT_VALID = 2'd2;
   localparam logic [1:0] DONE       = 2'd3;

   // The counter compare below underflows for a zero limit.
   if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
      $error("flash_read_ctrl: TIMEOUT_CYCLES must be at least 1");
   end

   logic [1:0]        state_q, state_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [3:0]        be_q, be_d;
   logic [DATA_W-1:0] data_q, data_d;
   logic              rd_done;
   logic              timeout_hit;

   // Real read data arrives either in the accepting ISSUE cycle (zero-latency
   // slave) or later in WAIT_VALID; readdatavalid in IDLE/DONE is ignored.
   assign rd_done = ((state_q == ISSUE) && !flash_mem_waitrequest && flash_mem_readdatavalid)
                  || ((state_q == WAIT_VALID) && flash_mem_readdatavalid);

`ifdef FLASH_TIMEOUT_EN
   localparam int               CNT_W    = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             err_q, err_d;

   // cnt_q holds the number of cycles already spent in ISSUE/WAIT_VALID, so
   // the cycle where it equals CNT_LAST is the last one allowed. Genuine data
   // arriving in that same cycle wins over the timeout.
   assign timeout_hit = ((state_q == ISSUE) || (state_q == WAIT_VALID))
                      && (cnt_q == CNT_LAST) && !rd_done;

   always_comb begin
      cnt_d = cnt_q;
      err_d = err_q;
      if ((state_q == IDLE) && start) begin
         cnt_d = '0;
         err_d = 1'b0;
      end else if ((state_q == ISSUE) || (state_q == WAIT_VALID)) begin
         cnt_d = cnt_q + 1'b1;
         if (timeout_hit) begin
            err_d = 1'b1;
         end
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         cnt_q <= '0;
         err_q <= 1'b0;
      end else begin
         cnt_q <= cnt_d;
         err_q <= err_d;
      end
   end

   assign timeout_err = err_q;
`else
   assign timeout_hit = 1'b0;
   assign timeout_err = 1'b0;
`endif

   always_comb begin
      state_d = state_q;
      addr_d  = addr_q;
      be_d    = be_q;
      data_d  = data_q;
      case (state_q)
         IDLE: begin
            if (start) begin
               addr_d  = address;
               be_d    = byteenable;
               state_d = ISSUE;
            end
         end
         ISSUE: begin
            if (rd_done) begin
               data_d  = flash_mem_readdata;
               state_d = DONE;
            end else if (timeout_hit) begin
               data_d  = '0;
               state_d = DONE;
            end else if (!flash_mem_waitrequest) begin
               state_d = WAIT_VALID;
            end
         end
         WAIT_VALID: begin
            if (rd_done) begin
               data_d  = flash_mem_readdata;
               state_d = DONE;
            end else if (timeout_hit) begin
               data_d  = '0;
               state_d = DONE;
            end
         end
         DONE: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= IDLE;
         addr_q  <= '0;
         be_q    <= '0;
         data_q  <= '0;
      end else begin
         state_q <= state_d;
         addr_q  <= addr_d;
         be_q    <= be_d;
         data_q  <= data_d;
      end
   end

   // Strobes decode straight from the state flop, so read is high exactly
   // while in ISSUE and finish exactly for the single DONE cycle.
   assign flash_mem_read       = (state_q == ISSUE);
   assign finish               = (state_q == DONE);
   assign flash_mem_address    = addr_q;
   assign flash_mem_byteenable = be_q;
   assign flash_mem_burstcount = 6'd1;
   assign data_out             = data_q;

endmodule
